// File: rtl/bsg_mesh_vc_link.sv
// Unidirectional multi-VC mesh link: round-robin VC arbitration into one registered link stage,
// per-VC credit-protected downstream FIFOs. Define BSG_MESH_VC_LINK_STATS_EN for flit/stall counters.
module bsg_mesh_vc_link #(
  parameter int unsigned width_p      = 16,
  parameter int unsigned vcs_p        = 2,
  parameter int unsigned els_p        = 4,
  parameter int unsigned stat_width_p = 16,
  localparam int unsigned cw_lp       = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [vcs_p-1:0]         v_i,
  input  logic [vcs_p*width_p-1:0] data_i,
  output logic [vcs_p-1:0]         ready_and_o,
  output logic [vcs_p-1:0]         v_o,
  output logic [vcs_p*width_p-1:0] data_o,
  input  logic [vcs_p-1:0]         yumi_i,
  output logic [vcs_p*cw_lp-1:0]   credit_o,
  output logic [stat_width_p-1:0]  xfer_count_o,
  output logic [stat_width_p-1:0]  stall_count_o
);

  localparam int unsigned vcw_lp = (vcs_p > 1) ? $clog2(vcs_p) : 1;
  localparam int unsigned ptr_lp = $clog2(els_p);
  localparam logic [cw_lp-1:0]  els_lp  = cw_lp'(els_p);
  localparam logic [ptr_lp-1:0] last_lp = ptr_lp'(els_p - 1);
  localparam logic [vcw_lp-1:0] rr_rst_lp = vcw_lp'(vcs_p - 1);

  logic [vcs_p-1:0][width_p-1:0] data_in, data_out;
  logic [vcs_p-1:0][cw_lp-1:0]   credit_r, credit_n;
  logic [vcs_p-1:0]              elig, grant;
  logic [vcw_lp-1:0]             grant_vc, rr_ptr_r, idx;
  logic                          xfer;

  logic                          link_v_r;
  logic [vcw_lp-1:0]             link_vc_r;
  logic [width_p-1:0]            link_data_r;

  logic [width_p-1:0]            mem_r [vcs_p][els_p];
  logic [vcs_p-1:0][cw_lp-1:0]   count_r;
  logic [vcs_p-1:0][ptr_lp-1:0]  wptr_r, rptr_r;
  logic [vcs_p-1:0]              fifo_wr, fifo_rd;

  assign data_in     = data_i;
  assign data_o      = data_out;
  assign credit_o    = credit_r;
  assign ready_and_o = grant;

  function automatic logic [ptr_lp-1:0] ptr_inc(input logic [ptr_lp-1:0] p);
    return (p == last_lp) ? '0 : p + 1'b1;
  endfunction

  // Gating with reset keeps ready_and_o low while reset is held, whatever v_i does.
  always_comb begin
    elig = '0;
    for (int c = 0; c < vcs_p; c++) begin
      elig[c] = reset_n_i & v_i[c] & (credit_r[c] != '0);
    end
  end

  always_comb begin
    grant    = '0;
    grant_vc = '0;
    xfer     = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= vcs_p; i++) begin
      idx = vcw_lp'((int'(rr_ptr_r) + i) % vcs_p);
      if (!xfer && elig[idx]) begin
        xfer        = 1'b1;
        grant[idx]  = 1'b1;
        grant_vc    = idx;
      end
    end
  end

  always_comb begin
    credit_n = credit_r;
    fifo_wr  = '0;
    fifo_rd  = '0;
    data_out = '0;
    for (int c = 0; c < vcs_p; c++) begin
      credit_n[c] = credit_r[c] + cw_lp'(yumi_i[c]) - cw_lp'(grant[c]);
      fifo_wr[c]  = link_v_r && (link_vc_r == vcw_lp'(c));
      fifo_rd[c]  = yumi_i[c] && v_o[c];
      data_out[c] = v_o[c] ? mem_r[c][rptr_r[c]] : '0;
    end
  end

  always_comb begin
    v_o = '0;
    for (int c = 0; c < vcs_p; c++) begin
      v_o[c] = (count_r[c] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r    <= rr_rst_lp;
      link_v_r    <= 1'b0;
      link_vc_r   <= '0;
      link_data_r <= '0;
      for (int c = 0; c < vcs_p; c++) begin
        credit_r[c] <= els_lp;
      end
    end else begin
      if (xfer) rr_ptr_r <= grant_vc;
      link_v_r    <= xfer;
      link_vc_r   <= grant_vc;
      link_data_r <= data_in[grant_vc];
      credit_r    <= credit_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
    end else begin
      for (int c = 0; c < vcs_p; c++) begin
        if (fifo_wr[c]) wptr_r[c] <= ptr_inc(wptr_r[c]);
        if (fifo_rd[c]) rptr_r[c] <= ptr_inc(rptr_r[c]);
        count_r[c] <= count_r[c] + cw_lp'(fifo_wr[c]) - cw_lp'(fifo_rd[c]);
      end
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (link_v_r) mem_r[link_vc_r][wptr_r[link_vc_r]] <= link_data_r;
  end

`ifdef BSG_MESH_VC_LINK_STATS_EN
  logic [stat_width_p-1:0] xfer_cnt_r, stall_cnt_r;
  logic                    stall_any;

  assign stall_any     = |(v_i & ~elig);
  assign xfer_count_o  = xfer_cnt_r;
  assign stall_count_o = stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      xfer_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (xfer && (xfer_cnt_r != '1))       xfer_cnt_r  <= xfer_cnt_r + 1'b1;
      if (stall_any && (stall_cnt_r != '1)) stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end
`else
  assign xfer_count_o  = '0;
  assign stall_count_o = '0;
`endif

`ifndef SYNTHESIS
  for (genvar c = 0; c < vcs_p; c++) begin : g_chk
    a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      yumi_i[c] |-> v_o[c]);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (fifo_wr[c] && !fifo_rd[c]) |-> (count_r[c] != els_lp));
  end
`endif

endmodule
